// File: rtl/debug_step_pkg.sv
// Shared command encodings, FSM state type and command classification for the
// debug single-step controller.
package debug_step_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   localparam byte_t CMD_PULSE = 8'h70;  // "p"
   localparam byte_t CMD_STEP  = 8'h73;  // "s"
   localparam byte_t CMD_CONT  = 8'h63;  // "c"
   localparam byte_t CMD_LEN   = 8'h6E;  // "n"
   localparam byte_t CMD_ABORT = 8'h78;  // "x"

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ARG = 2'd1,
      ST_STEP     = 2'd2,
      ST_CONT     = 2'd3
   } state_e;

   // A byte the current state would act on; only these can be dropped by a collision.
   function automatic logic cmd_honoured(input state_e st, input byte_t b);
      logic hit;
      hit = 1'b0;
      case (st)
         ST_IDLE:     hit = (b == CMD_PULSE) || (b == CMD_STEP) ||
                            (b == CMD_CONT)  || (b == CMD_LEN);
         ST_WAIT_ARG: hit = 1'b1;
         ST_STEP:     hit = (b == CMD_ABORT) || (b == CMD_STEP) || (b == CMD_PULSE);
         ST_CONT:     hit = (b == CMD_ABORT);
         default:     hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter that stops at zero; a tick at count 1 expires and either
// reloads or clears.
module step_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   input  logic             reload_i,
   input  logic [CNT_W-1:0] reload_val_i,
   output logic [CNT_W-1:0] count_o,
   output logic             expire_c
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign expire_c = en_i && (count_q == CNT_ONE);
   assign count_o  = count_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (expire_c) begin
         count_d = reload_i ? reload_val_i : CNT_ZERO;
      end else if (en_i && (count_q != CNT_ZERO)) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= CNT_ZERO;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug single-step controller: decodes UART command bytes into one-cycle
// trigger pulses, with programmable step length, continuous mode and abort.
module debug_step_ctrl
   import debug_step_pkg::*;
#(
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned DEFAULT_STEPS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_valid_i,
   input  logic [7:0]       rx_byte_i,
   input  logic             gb_tick_i,
   input  logic             halt_i,
   output logic             trigger_o,
   output logic             busy_o,
   output logic             cont_mode_o,
   output logic [CNT_W-1:0] count_o,
   output logic             cmd_drop_o
);

   localparam logic [CNT_W-1:0] DEF_LEN  = CNT_W'(DEFAULT_STEPS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_e           state_q,    state_d;
   logic [CNT_W-1:0] step_len_q, step_len_d;
   logic             trigger_q,  trigger_d;
   logic             busy_q,     busy_d;
   logic             cont_q,     cont_d;
   logic             drop_q,     drop_d;

   logic             tick_eff;
   logic             running;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_en;
   logic             cnt_reload;
   logic             cnt_expire;
   logic [CNT_W-1:0] count;

   assign tick_eff = gb_tick_i && !halt_i;
   assign running  = (state_q == ST_STEP) || (state_q == ST_CONT);

   // A tick is swallowed by a concurrent byte unless it is the one that expires.
   assign cnt_en     = tick_eff && running && ((count == CNT_ONE) || !rx_valid_i);
   assign cnt_reload = (state_q == ST_CONT);

   step_counter #(
      .CNT_W (CNT_W)
   ) u_step_counter (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (cnt_load),
      .load_val_i   (cnt_load_val),
      .en_i         (cnt_en),
      .reload_i     (cnt_reload),
      .reload_val_i (step_len_q),
      .count_o      (count),
      .expire_c     (cnt_expire)
   );

   always_comb begin
      state_d      = state_q;
      step_len_d   = step_len_q;
      trigger_d    = 1'b0;
      drop_d       = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = step_len_q;

      if (cnt_expire) begin
         trigger_d = 1'b1;
         drop_d    = rx_valid_i && cmd_honoured(state_q, rx_byte_i);
         if (state_q == ST_STEP) begin
            state_d = ST_IDLE;
         end
      end else if (rx_valid_i) begin
         case (state_q)
            ST_IDLE: begin
               case (rx_byte_i)
                  CMD_PULSE: trigger_d = 1'b1;
                  CMD_STEP: begin
                     trigger_d = 1'b1;
                     cnt_load  = 1'b1;
                     state_d   = ST_STEP;
                  end
                  CMD_CONT: begin
                     trigger_d = 1'b1;
                     cnt_load  = 1'b1;
                     state_d   = ST_CONT;
                  end
                  CMD_LEN:  state_d = ST_WAIT_ARG;
                  default:  ;
               endcase
            end
            ST_WAIT_ARG: begin
               step_len_d = (rx_byte_i == 8'h00) ? DEF_LEN : CNT_W'(rx_byte_i);
               state_d    = ST_IDLE;
            end
            ST_STEP: begin
               case (rx_byte_i)
                  CMD_ABORT: begin
                     cnt_load     = 1'b1;
                     cnt_load_val = CNT_ZERO;
                     state_d      = ST_IDLE;
                  end
                  CMD_STEP: begin
                     trigger_d = 1'b1;
                     cnt_load  = 1'b1;
                  end
                  CMD_PULSE: trigger_d = 1'b1;
                  default:   ;
               endcase
            end
            ST_CONT: begin
               if (rx_byte_i == CMD_ABORT) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = CNT_ZERO;
                  state_d      = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d == ST_STEP) || (state_d == ST_CONT);
      cont_d = (state_d == ST_CONT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         step_len_q <= DEF_LEN;
         trigger_q  <= 1'b0;
         busy_q     <= 1'b0;
         cont_q     <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_len_q <= step_len_d;
         trigger_q  <= trigger_d;
         busy_q     <= busy_d;
         cont_q     <= cont_d;
         drop_q     <= drop_d;
      end
   end

   assign trigger_o   = trigger_q;
   assign busy_o      = busy_q;
   assign cont_mode_o = cont_q;
   assign cmd_drop_o  = drop_q;
   assign count_o     = count;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the command rules.
module tb_debug_step_ctrl;

   localparam int unsigned CNT_W = 8;
   localparam int          DEF   = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             rx_valid = 1'b0;
   logic [7:0]       rx_byte = 8'h00;
   logic             gb_tick = 1'b0;
   logic             halt = 1'b0;
   logic             trigger;
   logic             busy;
   logic             cont_mode;
   logic [CNT_W-1:0] count;
   logic             cmd_drop;

   int checks = 0;
   int failures = 0;

   // Model: mode 0 idle, 1 waiting for argument, 2 stepping, 3 continuous.
   int m_mode, m_len, m_cnt;
   bit m_trig, m_drop;

   debug_step_ctrl #(.CNT_W(CNT_W), .DEFAULT_STEPS(DEF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_valid_i  (rx_valid),
      .rx_byte_i   (rx_byte),
      .gb_tick_i   (gb_tick),
      .halt_i      (halt),
      .trigger_o   (trigger),
      .busy_o      (busy),
      .cont_mode_o (cont_mode),
      .count_o     (count),
      .cmd_drop_o  (cmd_drop)
   );

   always #5 clk = ~clk;

   function automatic bit m_acts(int mode, logic [7:0] b);
      if (mode == 0) return b inside {"p", "s", "c", "n"};
      if (mode == 1) return 1'b1;
      if (mode == 2) return b inside {"x", "s", "p"};
      return b == "x";
   endfunction

   task automatic m_reset();
      m_mode = 0; m_len = DEF; m_cnt = 0; m_trig = 0; m_drop = 0;
   endtask

   task automatic m_step(input bit v, input logic [7:0] b, input bit t, input bit h);
      bit running;
      bit eff;
      running = (m_mode >= 2);
      eff = t && !h;
      m_trig = 0;
      m_drop = 0;
      if (running && eff && m_cnt == 1) begin
         m_trig = 1;
         m_drop = v && m_acts(m_mode, b);
         if (m_mode == 2) begin m_mode = 0; m_cnt = 0; end
         else m_cnt = m_len;
      end else if (v) begin
         if (m_mode == 0) begin
            if (b == "p") m_trig = 1;
            else if (b == "s") begin m_trig = 1; m_cnt = m_len; m_mode = 2; end
            else if (b == "c") begin m_trig = 1; m_cnt = m_len; m_mode = 3; end
            else if (b == "n") m_mode = 1;
         end else if (m_mode == 1) begin
            m_len = (b == 0) ? DEF : int'(b);
            m_mode = 0;
         end else if (m_mode == 2) begin
            if (b == "x") begin m_mode = 0; m_cnt = 0; end
            else if (b == "s") begin m_trig = 1; m_cnt = m_len; end
            else if (b == "p") m_trig = 1;
         end else if (b == "x") begin
            m_mode = 0; m_cnt = 0;
         end
      end else if (running && eff && m_cnt > 0) begin
         m_cnt = m_cnt - 1;
      end
   endtask

   // One clock: drive inputs, take the edge, advance the model, settle.
   task automatic cyc(input bit v, input logic [7:0] b, input bit t, input bit h);
      rx_valid = v; rx_byte = b; gb_tick = t; halt = h;
      @(posedge clk);
      m_step(v, b, t, h);
      #1;
      rx_valid = 1'b0; gb_tick = 1'b0; halt = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({trigger, busy, cont_mode, cmd_drop} !== 4'b0000 || count !== 8'd0) begin
         failures++;
         $display("FAIL reset_outputs: got trig=%b busy=%b cont=%b drop=%b count=%0d, want all 0",
                  trigger, busy, cont_mode, cmd_drop, count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_step_basic();
      cyc(1, "s", 0, 0);
      checks++;
      if (trigger !== 1'b1 || busy !== 1'b1 || count !== 8'd4) begin
         failures++;
         $display("FAIL step_start: trig=%b busy=%b count=%0d, want 1 1 4", trigger, busy, count);
      end
      for (int i = 1; i <= 4; i++) begin
         cyc(0, 8'h00, 1, 0);
         checks++;
         if (trigger !== (i == 4) || busy !== (i != 4) || count !== 8'(4 - i)) begin
            failures++;
            $display("FAIL step_tick%0d: trig=%b busy=%b count=%0d, want %b %b %0d",
                     i, trigger, busy, count, i == 4, i != 4, 4 - i);
         end
      end
      cyc(0, 8'h00, 1, 0);
      checks++;
      if (trigger !== 1'b0 || count !== 8'd0) begin
         failures++;
         $display("FAIL step_after_idle: trig=%b count=%0d, want 0 0", trigger, count);
      end
   endtask

   task automatic test_halt_len();
      int eff;
      cyc(1, "n", 0, 0);
      cyc(1, 8'h0A, 1, 0);
      checks++;
      if (trigger !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL len_arg_no_pulse: trig=%b busy=%b, want 0 0", trigger, busy);
      end
      cyc(1, "s", 1, 0);
      checks++;
      if (trigger !== 1'b1 || count !== 8'd10) begin
         failures++;
         $display("FAIL len10_start: trig=%b count=%0d, want 1 10", trigger, count);
      end
      eff = 0;
      for (int i = 1; i <= 13; i++) begin
         cyc(0, 8'h00, 1, (i >= 3 && i <= 5));
         if (!(i >= 3 && i <= 5)) eff++;
         checks++;
         if (trigger !== (eff == 10) || count !== 8'(10 - eff)) begin
            failures++;
            $display("FAIL halt_tick%0d: trig=%b count=%0d, want %b %0d",
                     i, trigger, count, eff == 10, 10 - eff);
         end
      end
   endtask

   task automatic test_len_zero();
      cyc(1, "n", 0, 0);
      cyc(1, 8'h00, 0, 0);
      cyc(1, "s", 0, 0);
      checks++;
      if (count !== 8'd4) begin
         failures++;
         $display("FAIL len_zero_default: count=%0d, want 4", count);
      end
      for (int i = 1; i <= 4; i++) begin
         cyc(0, 8'h00, 1, 0);
         checks++;
         if (trigger !== (i == 4)) begin
            failures++;
            $display("FAIL len_zero_tick%0d: trig=%b, want %b", i, trigger, i == 4);
         end
      end
   endtask

   task automatic test_cont();
      cyc(1, "n", 0, 0);
      cyc(1, 8'h02, 0, 0);
      cyc(1, "c", 0, 0);
      checks++;
      if (trigger !== 1'b1 || cont_mode !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL cont_start: trig=%b cont=%b busy=%b, want 1 1 1", trigger, cont_mode, busy);
      end
      for (int i = 1; i <= 7; i++) begin
         cyc(0, 8'h00, 1, 0);
         checks++;
         if (trigger !== (i % 2 == 0) || count !== 8'((i % 2 == 0) ? 2 : 1) || cont_mode !== 1'b1) begin
            failures++;
            $display("FAIL cont_tick%0d: trig=%b count=%0d cont=%b, want %b %0d 1",
                     i, trigger, count, cont_mode, i % 2 == 0, (i % 2 == 0) ? 2 : 1);
         end
      end
      cyc(1, "x", 0, 0);
      checks++;
      if (trigger !== 1'b0 || cont_mode !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
         failures++;
         $display("FAIL cont_abort: trig=%b cont=%b busy=%b count=%0d, want 0 0 0 0",
                  trigger, cont_mode, busy, count);
      end
   endtask

   task automatic test_collision();
      cyc(1, "n", 0, 0);
      cyc(1, 8'h01, 0, 0);
      cyc(1, "s", 0, 0);
      cyc(1, "p", 1, 0);
      checks++;
      if (trigger !== 1'b1 || cmd_drop !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
         failures++;
         $display("FAIL coll_p: trig=%b drop=%b busy=%b count=%0d, want 1 1 0 0",
                  trigger, cmd_drop, busy, count);
      end
      cyc(0, 8'h00, 0, 0);
      checks++;
      if (trigger !== 1'b0 || cmd_drop !== 1'b0) begin
         failures++;
         $display("FAIL coll_single_pulse: trig=%b drop=%b, want 0 0", trigger, cmd_drop);
      end
      cyc(1, "s", 0, 0);
      cyc(1, "q", 1, 0);
      checks++;
      if (trigger !== 1'b1 || cmd_drop !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL coll_ignored: trig=%b drop=%b busy=%b, want 1 0 0", trigger, cmd_drop, busy);
      end
      cyc(1, "n", 0, 0);
      cyc(1, 8'h03, 0, 0);
      cyc(1, "s", 0, 0);
      cyc(1, "p", 1, 0);
      checks++;
      if (trigger !== 1'b1 || cmd_drop !== 1'b0 || count !== 8'd3) begin
         failures++;
         $display("FAIL tick_discard: trig=%b drop=%b count=%0d, want 1 0 3", trigger, cmd_drop, count);
      end
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(1, "p", 0, 0);
      cyc(0, 8'h00, 1, 0);
      checks++;
      if (trigger !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL back_to_back: trig=%b busy=%b, want 1 0", trigger, busy);
      end
   endtask

   task automatic test_reset_mid();
      cyc(1, "n", 0, 0);
      cyc(1, 8'h05, 0, 0);
      cyc(1, "s", 0, 0);
      repeat (3) cyc(0, 8'h00, 1, 0);
      cyc(1, "p", 0, 0);
      checks++;
      if (trigger !== 1'b1 || count !== 8'd2) begin
         failures++;
         $display("FAIL pre_reset: trig=%b count=%0d, want 1 2", trigger, count);
      end
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      checks++;
      if ({trigger, busy, cont_mode, cmd_drop} !== 4'b0000 || count !== 8'd0) begin
         failures++;
         $display("FAIL async_reset: trig=%b busy=%b cont=%b drop=%b count=%0d, want all 0",
                  trigger, busy, cont_mode, cmd_drop, count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1, "s", 0, 0);
      checks++;
      if (count !== 8'd4 || trigger !== 1'b1) begin
         failures++;
         $display("FAIL reset_default_len: count=%0d trig=%b, want 4 1", count, trigger);
      end
      cyc(1, "x", 0, 0);
   endtask

   task automatic test_random();
      logic [7:0] tbl [10];
      logic [7:0] b;
      bit v, t, h;
      tbl = '{"p", "s", "c", "n", "x", "q", 8'h00, 8'h01, 8'h02, 8'h03};
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(3) == 0);
         t = ($urandom_range(1) == 0);
         h = ($urandom_range(6) == 0);
         b = tbl[$urandom_range(9)];
         cyc(v, b, t, h);
         checks++;
         if (trigger !== m_trig || cmd_drop !== m_drop || busy !== (m_mode >= 2) ||
             cont_mode !== (m_mode == 3) || count !== 8'(m_cnt)) begin
            failures++;
            $display("FAIL random_cyc%0d: trig=%b drop=%b busy=%b cont=%b count=%0d, want %b %b %b %b %0d",
                     i, trigger, cmd_drop, busy, cont_mode, count,
                     m_trig, m_drop, m_mode >= 2, m_mode == 3, m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_step_basic();
      test_halt_len();
      test_len_zero();
      test_cont();
      test_collision();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
